// File: rtl/mem_pkg.sv
// Shared types, func3 codes, strobe patterns and store-lane helpers for the
// data-memory access unit.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // func3 encodings shared by loads and stores
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Byte-lane write strobes
  localparam logic [3:0] STRB_NONE    = 4'b0000;
  localparam logic [3:0] STRB_BYTE0   = 4'b0001;
  localparam logic [3:0] STRB_HALF_LO = 4'b0011;
  localparam logic [3:0] STRB_HALF_HI = 4'b1100;
  localparam logic [3:0] STRB_WORD    = 4'b1111;

  // Exactly one of read/write, a func3 legal for that direction, and an
  // address aligned to the access width.
  function automatic logic access_ok(input logic       rd,
                                     input logic       wr,
                                     input logic [2:0] func3,
                                     input logic [1:0] addr_lo);
    logic legal;
    logic aligned;
    if (rd) begin
      legal = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W) ||
              (func3 == F3_BU) || (func3 == F3_HU);
    end else begin
      legal = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W);
    end
    case (func3[1:0])
      2'd1:    aligned = ~addr_lo[0];
      2'd2:    aligned = (addr_lo == 2'b00);
      default: aligned = 1'b1;
    endcase
    return (rd ^ wr) && legal && aligned;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] func3,
                                            input logic [1:0] addr_lo);
    case (func3)
      F3_B:    return STRB_BYTE0 << addr_lo;
      F3_H:    return addr_lo[1] ? STRB_HALF_HI : STRB_HALF_LO;
      F3_W:    return STRB_WORD;
      default: return STRB_NONE;
    endcase
  endfunction

  // Replicate the store operand so every enabled lane carries it.
  function automatic logic [31:0] store_data(input logic [2:0]  func3,
                                             input logic [31:0] data);
    case (func3)
      F3_B:    return {4{data[7:0]}};
      F3_H:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-lane selection and sign/zero extension.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  func3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed byte lane out of the returned word.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves the signal unassigned and infers a latch.
    byte_lane = rdata_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_lane = rdata_i[15:8];
      2'd2:    byte_lane = rdata_i[23:16];
      2'd3:    byte_lane = rdata_i[31:24];
      default: byte_lane = rdata_i[7:0];
    endcase
  end

  assign half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // Extend the selected lane by load width and signedness; words pass through.
  always_comb begin
    data_o = rdata_i;
    case (func3_i)
      F3_B:    data_o = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    data_o = {{16{half_lane[15]}}, half_lane};
      F3_BU:   data_o = {24'b0, byte_lane};
      F3_HU:   data_o = {16'b0, half_lane};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: validates the access, drives a
// req/ready memory handshake with timeout, and aligns load data.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_in_memRead,
  input  logic        mem_in_memWrite,
  input  logic [31:0] mem_in_aluOut,
  input  logic [31:0] mem_in_data2,
  input  logic [31:0] mem_in_instr,
  output logic [31:0] mem_out_dataMemOut,
  output logic        mem_out_stall,
  output logic        mem_out_error,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  logic             req_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [1:0]       addr_lo_q;
  logic [2:0]       func3_q;
  logic [3:0]       strb_q;
  logic [31:0]      wdata_q;
  logic [31:0]      data_q;
  logic             error_q;
  logic [CNT_W-1:0] cnt_q;

  logic [2:0]       func3;
  logic             access;
  logic             access_good;
  logic [31:0]      load_d;
  logic             unused_instr_bits;

  assign func3       = mem_in_instr[14:12];
  assign access      = mem_in_memRead | mem_in_memWrite;
  assign access_good = access_ok(mem_in_memRead, mem_in_memWrite, func3,
                                 mem_in_aluOut[1:0]);
  assign unused_instr_bits = ^{mem_in_instr[31:15], mem_in_instr[11:0]};

  load_align u_load_align (
    .rdata_i   (dmem_rdata),
    .addr_lo_i (addr_lo_q),
    .func3_i   (func3_q),
    .data_o    (load_d)
  );

  // Freeze the pipeline as soon as a good access shows up, and for all of BUSY.
  assign mem_out_stall = rst_n &&
                         (((state_q == ST_IDLE) && access && access_good) ||
                          (state_q == ST_BUSY));

  // Access FSM with its request latches, wait counter and registered results.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      addr_lo_q <= '0;
      func3_q   <= '0;
      strb_q    <= STRB_NONE;
      wdata_q   <= '0;
      data_q    <= '0;
      error_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (access && access_good) begin
            state_q   <= ST_BUSY;
            req_q     <= 1'b1;
            we_q      <= mem_in_memWrite;
            addr_q    <= {mem_in_aluOut[31:2], 2'b00};
            addr_lo_q <= mem_in_aluOut[1:0];
            func3_q   <= func3;
            strb_q    <= mem_in_memWrite ? store_strb(func3, mem_in_aluOut[1:0])
                                         : STRB_NONE;
            wdata_q   <= mem_in_memWrite ? store_data(func3, mem_in_data2) : '0;
            cnt_q     <= '0;
          end else if (access) begin
            error_q <= 1'b1;
            data_q  <= '0;
          end
        end
        ST_BUSY: begin
          if (dmem_ready) begin
            state_q <= ST_DONE;
            req_q   <= 1'b0;
            if (!we_q) begin
              data_q <= load_d;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              state_q <= ST_DONE;
              req_q   <= 1'b0;
              error_q <= 1'b1;
              data_q  <= '0;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dmem_req           = req_q;
  assign dmem_we            = we_q;
  assign dmem_addr          = addr_q;
  assign dmem_wstrb         = strb_q;
  assign dmem_wdata         = wdata_q;
  assign mem_out_dataMemOut = data_q;
  assign mem_out_error      = error_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed literal cases plus a
// randomized run compared every cycle against a transaction-level model.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd, wr;
  logic [31:0] alu, d2, instr;
  logic [31:0] dout;
  logic        stall, err, req, we;
  logic [31:0] daddr, wdata, rdata;
  logic [3:0]  strb;
  logic        ready;

  logic        mem_random = 1'b0;
  logic        rnd_ready = 1'b0;
  logic        dir_ready = 1'b0;
  logic [31:0] rnd_rdata = '0;
  logic [31:0] dir_rdata = '0;
  logic        cmp_en = 1'b0;

  int checks = 0;
  int failures = 0;

  assign ready = mem_random ? rnd_ready : dir_ready;
  assign rdata = mem_random ? rnd_rdata : dir_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .mem_in_memRead     (rd),
    .mem_in_memWrite    (wr),
    .mem_in_aluOut      (alu),
    .mem_in_data2       (d2),
    .mem_in_instr       (instr),
    .mem_out_dataMemOut (dout),
    .mem_out_stall      (stall),
    .mem_out_error      (err),
    .dmem_req           (req),
    .dmem_we            (we),
    .dmem_addr          (daddr),
    .dmem_wstrb         (strb),
    .dmem_wdata         (wdata),
    .dmem_rdata         (rdata),
    .dmem_ready         (ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_legal(input bit r, input bit w, input logic [2:0] f3,
                                 input logic [31:0] a);
    int size;
    if (r && w) return 0;
    if (!r && !w) return 0;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    return 0;
    endcase
    if (w && f3 > 3'd2) return 0;
    return (int'(a % 32'd4) % size) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [31:0] a,
                                         input logic [2:0] f3);
    logic [31:0] s;
    s = word >> ((a % 32'd4) * 32'd8);
    case (f3)
      3'd0: return s[7]  ? (s & 32'hFF) - 32'h100 : (s & 32'hFF);
      3'd1: return s[15] ? (s & 32'hFFFF) - 32'h10000 : (s & 32'hFFFF);
      3'd4: return s & 32'hFF;
      3'd5: return s & 32'hFFFF;
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0:    return 4'(32'd1 << (a % 32'd4));
      3'd1:    return 4'(32'd3 << (a % 32'd4));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0:    return (d & 32'hFF) * 32'h01010101;
      3'd1:    return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  bit          m_busy = 0, m_done = 0;
  int          m_wait = 0;
  logic        m_we = 0;
  logic [31:0] m_addr = '0;
  logic [2:0]  m_f3 = '0;
  logic        e_req = 0, e_we = 0, e_err = 0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_dout = '0;
  logic [3:0]  e_strb = '0;

  // Transaction-level reference: one access in flight, one release cycle after it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_wait = 0; m_we = 0; m_addr = '0; m_f3 = '0;
      e_req = 0; e_we = 0; e_err = 0; e_addr = '0; e_wdata = '0; e_dout = '0; e_strb = '0;
    end else begin
      e_err = 0;
      if (m_done) begin
        m_done = 0;
      end else if (m_busy) begin
        if (ready) begin
          m_busy = 0; m_done = 1; e_req = 0;
          if (!m_we) e_dout = m_load(rdata, m_addr, m_f3);
        end else begin
          m_wait++;
          if (m_wait == TO) begin
            m_busy = 0; m_done = 1; e_req = 0; e_err = 1; e_dout = '0;
          end
        end
      end else if (rd || wr) begin
        if (m_legal(rd, wr, instr[14:12], alu)) begin
          m_busy = 1; m_wait = 0; m_we = wr; m_addr = alu; m_f3 = instr[14:12];
          e_req = 1; e_we = wr; e_addr = alu & ~32'h3;
          e_strb = m_strb(instr[14:12], alu);
          e_wdata = m_wdata(instr[14:12], d2);
        end else begin
          e_err = 1; e_dout = '0;
        end
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      logic exp_stall;
      exp_stall = m_busy || (!m_done && m_legal(rd, wr, instr[14:12], alu));
      check("stall", stall, exp_stall);
      check("req", req, e_req);
      check("error", err, e_err);
      check("dout", dout, e_dout);
      if (e_req) begin
        check("we", we, e_we);
        check("addr", daddr, e_addr);
        if (e_we) begin
          check("wstrb", strb, e_strb);
          check("wdata", wdata, e_wdata);
        end
      end
    end
  end

  // Random memory responder.
  always @(posedge clk) begin
    #1;
    rnd_ready = 1'($urandom_range(0, 1));
    rnd_rdata = $urandom();
  end

  // ---------------- stimulus ----------------
  task automatic drive_idle();
    rd = 0; wr = 0; alu = '0; d2 = '0; instr = '0;
  endtask

  task automatic set_access(input bit r, input bit w, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d);
    rd = r; wr = w; alu = a; d2 = d;
    instr = $urandom();
    instr[14:12] = f3;
  endtask

  logic        s0, s1, s2, rq1, rq2;
  logic [3:0]  o_strb;
  logic [31:0] o_wdata, o_addr, o_dout;

  // Present an access, answer ready in the following cycle, sample N..N+2.
  task automatic directed(input bit r, input bit w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdv);
    @(posedge clk); #1;
    set_access(r, w, f3, a, d); dir_ready = 0; dir_rdata = rdv;
    @(negedge clk); s0 = stall;
    @(posedge clk); #1; dir_ready = 1;
    @(negedge clk); s1 = stall; rq1 = req; o_strb = strb; o_wdata = wdata; o_addr = daddr;
    @(posedge clk); #1; dir_ready = 0;
    @(negedge clk); s2 = stall; rq2 = req; o_dout = dout;
    @(posedge clk); #1; drive_idle();
  endtask

  int          req_cycles, err_at, err_cnt;
  logic        stall_err;
  logic [31:0] dout_err;
  logic [2:0]  load_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0]  store_f3 [3] = '{3'd0, 3'd1, 3'd2};

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_idle();
    set_access(0, 1, 3'd2, 32'h104, 32'h11223344);
    dir_ready = 1;
    #12;
    check("rst_req", req, 0);
    check("rst_stall", stall, 0);
    check("rst_error", err, 0);
    check("rst_dout", dout, 0);
    check("rst_we", we, 0);
    check("rst_wstrb", strb, 0);
    check("rst_wdata", wdata, 0);
    check("rst_addr", daddr, 0);
    drive_idle(); dir_ready = 0;
    @(posedge clk); #1; rst_n = 1; cmp_en = 1;

    // sw 0x104
    directed(0, 1, 3'd2, 32'h104, 32'hDEADBEEF, 32'h0);
    check("sw_stall_n", s0, 1); check("sw_stall_n1", s1, 1); check("sw_stall_n2", s2, 0);
    check("sw_req_n1", rq1, 1); check("sw_req_n2", rq2, 0);
    check("sw_wstrb", o_strb, 4'b1111); check("sw_wdata", o_wdata, 32'hDEADBEEF);
    check("sw_addr", o_addr, 32'h104);

    // sb 0x103
    directed(0, 1, 3'd0, 32'h103, 32'h000000A5, 32'h0);
    check("sb_wstrb", o_strb, 4'b1000); check("sb_wdata", o_wdata, 32'hA5A5A5A5);
    check("sb_addr", o_addr, 32'h100);

    // lb / lhu 0x102
    directed(1, 0, 3'd0, 32'h102, 32'h0, 32'h0080FF00);
    check("lb_dout", o_dout, 32'hFFFFFF80); check("lb_stall_n2", s2, 0);
    directed(1, 0, 3'd5, 32'h102, 32'h0, 32'h0080FF00);
    check("lhu_dout", o_dout, 32'h00000080);

    // timeout with ready held low
    @(posedge clk); #1;
    set_access(1, 0, 3'd2, 32'h108, 32'h0); dir_ready = 0;
    req_cycles = 0; err_at = -1; err_cnt = 0; stall_err = 1; dout_err = 32'hFFFFFFFF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req) req_cycles++;
      if (err) begin
        err_cnt++;
        if (err_at < 0) begin err_at = c; stall_err = stall; dout_err = dout; end
      end
      @(posedge clk); #1;
      if (c > 0 && !stall) drive_idle();
    end
    check("to_req_cycles", req_cycles, 4);
    check("to_err_cycle", err_at, 5);
    check("to_err_count", err_cnt, 1);
    check("to_stall_at_err", stall_err, 0);
    check("to_dout", dout_err, 0);

    directed(1, 0, 3'd2, 32'h10C, 32'h0, 32'h12345678);
    check("lw_after_to", o_dout, 32'h12345678);

    // misaligned lw 0x106
    @(posedge clk); #1;
    set_access(1, 0, 3'd2, 32'h106, 32'h0);
    @(negedge clk);
    check("mis_stall", stall, 0); check("mis_req", req, 0);
    @(posedge clk); #1; drive_idle();
    @(negedge clk);
    check("mis_error", err, 1); check("mis_dout", dout, 0);
    check("mis_req_n1", req, 0); check("mis_stall_n1", stall, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mis_error_clear", err, 0);

    directed(1, 0, 3'd2, 32'h110, 32'h0, 32'h0BADF00D);
    check("lw_before_rst", o_dout, 32'h0BADF00D);

    // reset in the 2nd BUSY cycle of a store
    @(posedge clk); #1;
    set_access(0, 1, 3'd2, 32'h114, 32'h55AA55AA); dir_ready = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rb_req_busy", req, 1);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    check("rb_req", req, 0); check("rb_stall", stall, 0); check("rb_error", err, 0);
    check("rb_dout", dout, 0); check("rb_we", we, 0); check("rb_wstrb", strb, 0);
    check("rb_wdata", wdata, 0); check("rb_addr", daddr, 0);
    @(posedge clk); #1; drive_idle(); rst_n = 1;

    directed(1, 0, 3'd2, 32'h118, 32'h0, 32'hCAFEF00D);
    check("lw_after_rst_stall", s0, 1); check("lw_after_rst_done", s2, 0);
    check("lw_after_rst_dout", o_dout, 32'hCAFEF00D);

    // randomized traffic against the model
    mem_random = 1;
    for (int i = 0; i < 300; i++) begin
      bit          r, w;
      int          kind, n_idle, budget;
      logic [2:0]  f3;
      logic [31:0] a;
      @(posedge clk); #1;
      n_idle = $urandom_range(0, 2);
      for (int k = 0; k < n_idle; k++) begin
        drive_idle();
        @(posedge clk); #1;
      end
      kind = $urandom_range(0, 9);
      r = (kind < 5) || (kind == 9);
      w = (kind >= 5);
      if ($urandom_range(0, 9) < 8)
        f3 = (w && !r) ? store_f3[$urandom_range(0, 2)] : load_f3[$urandom_range(0, 4)];
      else
        f3 = 3'($urandom_range(0, 7));
      a = 32'h200 + $urandom_range(0, 63);
      if ($urandom_range(0, 9) < 7) begin
        if (f3[1:0] == 2'd1) a[0] = 1'b0;
        if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
      end
      set_access(r, w, f3, a, $urandom());
      budget = 0;
      forever begin
        @(negedge clk);
        if (!stall) break;
        budget++;
        if (budget > 20) begin
          check("stall_bound", stall, 0);
          break;
        end
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1; drive_idle();
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum cycles waiting for dmem_ready before abort.
REQ-002 SHALL have ports clk (in, 1, clock) and rst_n (in, 1, reset); one clock, reset asynchronous and active-low.
REQ-003 SHALL have mem_in_memRead, in, 1: load request from the EX/MEM register.
REQ-004 SHALL have mem_in_memWrite, in, 1: store request from the EX/MEM register.
REQ-005 SHALL have mem_in_aluOut, in, 32: byte address.
REQ-006 SHALL have mem_in_data2, in, 32: store data.
REQ-007 SHALL have mem_in_instr, in, 32: instruction; func3 = bits [14:12].
REQ-008 SHALL have mem_out_dataMemOut, out, 32: aligned and extended load data, to MEM/WB and forwarding.
REQ-009 SHALL have mem_out_stall, out, 1: freeze PC, IF/ID, ID/EX and EX/MEM.
REQ-010 SHALL have mem_out_error, out, 1: one-cycle pulse on misaligned access, illegal func3 or timeout.
REQ-011 SHALL have dmem_req (out, 1), dmem_we (out, 1), dmem_addr (out, 32, bits [1:0] = 0), dmem_wstrb (out, 4) and dmem_wdata (out, 32).
REQ-012 SHALL have dmem_rdata (in, 32) and dmem_ready (in, 1; rdata valid while ready = 1).

Function
REQ-013 SHALL implement FSM IDLE, BUSY, DONE.
REQ-014 IDLE, access present (read or write), legal and aligned: SHALL assert stall combinationally, latch address, we, wstrb, wdata and func3, then go BUSY.
REQ-015 IDLE, access illegal or misaligned: SHALL issue no request and no stall, pulse error next cycle, set dataMemOut to 0 and stay IDLE.
REQ-016 Alignment rules: word requires addr[1:0] = 0; half requires addr[0] = 0.
REQ-017 Legal load func3 values: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu. Legal store func3 values: 0 sb, 1 sh, 2 sw.
REQ-018 memRead and memWrite both high SHALL be treated as illegal.
REQ-019 BUSY: SHALL hold req = 1 and stall = 1 with all dmem outputs stable until the cycle ready = 1.
REQ-020 In the ready cycle SHALL register the load result into dataMemOut and go DONE.
REQ-021 DONE: stall = 0 and req = 0 for exactly one cycle so the pipeline advances; SHALL go IDLE unconditionally.
REQ-022 Minimum latency: access presented at cycle N, ready at N+1, dataMemOut valid and stall low at N+2.
REQ-023 Store lanes: sb SHALL drive wstrb = 1 << addr[1:0] and wdata = four copies of data2[7:0].
REQ-024 Store lanes: sh SHALL drive wstrb 0011 or 1100 by addr[1] and wdata = two copies of data2[15:0].
REQ-025 Store lanes: sw SHALL drive wstrb 1111 and wdata = data2.
REQ-026 Loads SHALL select the lane by addr[1:0]; lb and lh sign-extend, lbu and lhu zero-extend, lw passes through.
REQ-027 dataMemOut SHALL hold its value until the next completed load or error.
REQ-028 Wait counter: cleared on entry to BUSY, increments each BUSY cycle with ready = 0.
REQ-029 When the counter reaches TIMEOUT: drop req, pulse error, set dataMemOut = 0, go DONE.
REQ-030 ready = 1 outside BUSY SHALL be ignored.

Reset
REQ-031 rst_n low SHALL force IDLE asynchronously, including mid-BUSY (the access is abandoned).
REQ-032 Reset values: req = 0, we = 0, wstrb = 0, addr = 0, wdata = 0, dataMemOut = 0, error = 0, counter = 0.
REQ-033 stall SHALL be 0 during reset.

Structure
REQ-034 Package mem_pkg SHALL hold the func3 constants, FSM state encoding and strobe constants.
REQ-035 The sub-module load_align (combinational lane select and extend) SHALL be instantiated once.
REQ-036 All FSM, latch and counter state SHALL be registered in this module.

Verification
REQ-037 sw addr 0x104, data 0xDEADBEEF, ready at N+1 -> wstrb 1111, wdata 0xDEADBEEF, stall high at N and N+1, low at N+2.
REQ-038 sb addr 0x103, data 0x000000A5 -> wstrb 1000, wdata 0xA5A5A5A5.
REQ-039 lb addr 0x102, rdata 0x0080FF00 -> dataMemOut 0xFFFFFF80. lhu addr 0x102, same rdata -> 0x00000080.
REQ-040 lw addr 0x106 -> no req, error pulse, stall never asserted, dataMemOut 0.
REQ-041 ready held low with TIMEOUT = 4 -> req high for 4 cycles, then error pulse and return to IDLE.
REQ-042 rst_n low at the 2nd BUSY cycle -> req, stall and all outputs 0 immediately; a following lw completes normally.
